// File: rtl/inst_queue_issue_ctrl.sv
// Instruction queue and issue sequencer between fetch and decode; serializing ops
// issue only into an empty backend. Optional fetch->decode bypass: INST_QUEUE_BYPASS_EN.
module inst_queue_issue_ctrl #(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             fetch_valid,
   input  logic [31:0]      fetch_inst,
   input  logic [31:0]      fetch_pc,
   output logic             fetch_ready,
   output logic             dec_valid,
   output logic [31:0]      dec_inst,
   output logic [31:0]      dec_pc,
   input  logic             dec_serial,
   input  logic             dec_ready,
   input  logic             pipe_empty,
   output logic             serial_stall,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      SOLO  = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      inst_mem [DEPTH];
   logic [31:0]      pc_mem   [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      last_inst, last_pc;
   logic             empty, full;
   logic             bypass, issue, consume, push, pop;

   assign empty        = (cnt == '0);
   assign full         = (cnt == CNT_W'(DEPTH));
   assign fetch_ready  = !full;
   assign count        = cnt;
   assign serial_stall = (state != RUN);

   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      bypass    = 1'b0;
      dec_inst  = empty ? last_inst : inst_mem[rd_ptr];
      dec_pc    = empty ? last_pc   : pc_mem[rd_ptr];
      dec_valid = 1'b0;
      state_nxt = state;

      case (state)
         RUN:     dec_valid = !empty && (!dec_serial || pipe_empty);
         DRAIN:   dec_valid = !empty && pipe_empty;
         default: dec_valid = 1'b0;
      endcase

`ifdef INST_QUEUE_BYPASS_EN
      // An empty queue in RUN hands the fetch slot straight to the decoder.
      bypass = empty && (state == RUN) && !flush;
      if (bypass) begin
         dec_inst  = fetch_inst;
         dec_pc    = fetch_pc;
         dec_valid = fetch_valid && (!dec_serial || pipe_empty);
      end
`endif

      if (flush)
         dec_valid = 1'b0;

      issue   = dec_valid && dec_ready;
      consume = bypass && issue;
      pop     = issue && !consume;
      push    = fetch_valid && !full && !flush && !consume;

      case (state)
         RUN: begin
            if (issue && dec_serial)
               state_nxt = SOLO;
            else if (!empty && dec_serial && !pipe_empty)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (issue)
               state_nxt = SOLO;
         end
         SOLO: begin
            // Entered on the issuing edge, so pipe_empty is only sampled from
            // the first SOLO cycle onward.
            if (pipe_empty)
               state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase

      if (flush)
         state_nxt = RUN;
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         cnt       <= '0;
         last_inst <= '0;
         last_pc   <= '0;
      end else begin
         state <= state_nxt;
         if (!empty) begin
            last_inst <= inst_mem[rd_ptr];
            last_pc   <= pc_mem[rd_ptr];
         end else if (bypass && fetch_valid) begin
            last_inst <= fetch_inst;
            last_pc   <= fetch_pc;
         end
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   cnt <= cnt + CNT_W'(1);
               2'b01:   cnt <= cnt - CNT_W'(1);
               default: cnt <= cnt;
            endcase
         end
      end
   end

   // NOTE: the storage array has no reset; entries are only read after being
   // written, and empty-queue outputs come from the reset last_* registers.
   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem[wr_ptr] <= fetch_inst;
         pc_mem[wr_ptr]   <= fetch_pc;
      end
   end

endmodule

// File: tb/tb_inst_queue_issue_ctrl.sv
// Scoreboard bench for inst_queue_issue_ctrl: directed scenarios then random traffic,
// checked against a queue-level model of the issue rules and a simple backend model.
module tb_inst_queue_issue_ctrl;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             fetch_valid;
   logic [31:0]      fetch_inst;
   logic [31:0]      fetch_pc;
   logic             fetch_ready;
   logic             dec_valid;
   logic [31:0]      dec_inst;
   logic [31:0]      dec_pc;
   logic             dec_serial;
   logic             dec_ready;
   logic             pipe_empty;
   logic             serial_stall;
   logic [CNT_W-1:0] count;

   inst_queue_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .fetch_valid  (fetch_valid),
      .fetch_inst   (fetch_inst),
      .fetch_pc     (fetch_pc),
      .fetch_ready  (fetch_ready),
      .dec_valid    (dec_valid),
      .dec_inst     (dec_inst),
      .dec_pc       (dec_pc),
      .dec_serial   (dec_serial),
      .dec_ready    (dec_ready),
      .pipe_empty   (pipe_empty),
      .serial_stall (serial_stall),
      .count        (count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   entry_t      mq[$];      // model of queue contents
   entry_t      sb[$];      // expected issue order for the monitor
   int          backend[$]; // remaining cycles of each in-flight instruction
   bit          solo;       // a serializing op issued, waiting for backend drain
   bit          drain;      // serializing head has been waiting for backend drain
   int          lat_sel;
   int          checks;
   int          errors;
   logic [31:0] pc_next;
   entry_t      mon_e;

   // Decoder view: COP0 ops (MTC0/MFC0/TLB*/ERET), SYSCALL, BREAK serialize.
   function automatic logic is_serial(input logic [31:0] i);
      return (i[31:26] == 6'h10) ||
             (i[31:26] == 6'h00 && (i[5:0] == 6'h0C || i[5:0] == 6'h0D));
   endfunction

   assign dec_serial = is_serial(dec_inst);

   function automatic logic [31:0] alu_op();
      logic [31:0] r;
      r = $urandom();
      return {6'h09, r[25:0]};
   endfunction

   function automatic logic [31:0] serial_op();
      case ($urandom_range(0, 4))
         0:       return 32'h4080_6000;
         1:       return 32'h4200_0018;
         2:       return 32'h4200_0002;
         3:       return 32'h0000_000C;
         default: return 32'h0000_000D;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every handshake on the decode side must match the scoreboard head.
   always @(negedge clk) begin
      if (rst === 1'b0 && dec_valid === 1'b1 && dec_ready === 1'b1 && flush === 1'b0) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL issue_unexpected: got inst %0h with empty scoreboard", dec_inst);
         end else begin
            mon_e = sb.pop_front();
            check("dec_inst", dec_inst, mon_e.inst);
            check("dec_pc", dec_pc, mon_e.pc);
         end
      end
   end

   task automatic do_reset();
      rst         = 1'b1;
      flush       = 1'b0;
      fetch_valid = 1'b0;
      fetch_inst  = '0;
      fetch_pc    = '0;
      dec_ready   = 1'b0;
      mq.delete();
      sb.delete();
      backend.delete();
      solo        = 1'b0;
      drain       = 1'b0;
      pipe_empty  = 1'b1;
      #1;
      check("rst_dec_valid", dec_valid, 1'b0);
      check("rst_fetch_ready", fetch_ready, 1'b1);
      check("rst_dec_inst", dec_inst, 32'h0);
      check("rst_dec_pc", dec_pc, 32'h0);
      check("rst_serial_stall", serial_stall, 1'b0);
      check("rst_count", count, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst     = 1'b0;
      pc_next = 32'hBFC0_0000;
   endtask

   // One clock cycle: drive, check outputs mid-cycle, then advance the model.
   task automatic cyc(input bit fv, input logic [31:0] inst, input bit dr, input bit fl);
      bit exp_valid, exp_stall, head_ser, issue, accept;
      fetch_valid = fv;
      fetch_inst  = inst;
      fetch_pc    = pc_next;
      dec_ready   = dr;
      flush       = fl;
      head_ser    = (mq.size() > 0) && is_serial(mq[0].inst);
      exp_valid   = !fl && !solo && (mq.size() > 0) && (!head_ser || pipe_empty);
      exp_stall   = solo || drain;

      @(negedge clk);
      check("dec_valid", dec_valid, exp_valid);
      check("count", count, mq.size());
      check("fetch_ready", fetch_ready, mq.size() != DEPTH);
      check("serial_stall", serial_stall, exp_stall);

      @(posedge clk);
      issue  = exp_valid && dr;
      accept = fv && (mq.size() != DEPTH) && !fl;
      if (fl) begin
         mq.delete();
         sb.delete();
         solo  = 1'b0;
         drain = 1'b0;
      end else begin
         if (issue) begin
            void'(mq.pop_front());
            solo  = head_ser;
            drain = 1'b0;
         end else if (solo) begin
            if (pipe_empty)
               solo = 1'b0;
         end else if (head_ser && !pipe_empty) begin
            drain = 1'b1;
         end
         if (accept) begin
            mq.push_back({inst, pc_next});
            sb.push_back({inst, pc_next});
            pc_next += 32'd4;
         end
      end
      for (int i = backend.size() - 1; i >= 0; i--) begin
         backend[i]--;
         if (backend[i] <= 0)
            backend.delete(i);
      end
      if (issue)
         backend.push_back(lat_sel);
      #1;
      pipe_empty = (backend.size() == 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks  = 0;
      errors  = 0;
      lat_sel = 1;
      pc_next = 32'hBFC0_0000;

      // Reset, then a single instruction with one cycle of latency.
      do_reset();
      cyc(1'b1, 32'h2402_0001, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b1, 1'b0);

      // Fill to DEPTH, refuse a 9th, pop while full, then drain; three rounds.
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < DEPTH + 1; i++)
            cyc(1'b1, alu_op(), 1'b0, 1'b0);
         cyc(1'b1, alu_op(), 1'b1, 1'b0);
         cyc(1'b1, alu_op(), 1'b0, 1'b0);
         idle(DEPTH + 1);
      end

      // MTC0 behind an in-flight op: DRAIN, issue, then SOLO holds the follower.
      lat_sel = 4;
      cyc(1'b1, alu_op(), 1'b1, 1'b0);
      cyc(1'b1, 32'h4080_6000, 1'b1, 1'b0);
      cyc(1'b1, alu_op(), 1'b1, 1'b0);
      idle(12);

      // Four ALU ops issue back-to-back.
      lat_sel = 1;
      for (int i = 0; i < 4; i++)
         cyc(1'b1, alu_op(), 1'b0, 1'b0);
      idle(5);

      // Flush with five entries while draining, fetch offered in the same cycle.
      lat_sel = 30;
      cyc(1'b1, alu_op(), 1'b1, 1'b0);
      cyc(1'b1, serial_op(), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++)
         cyc(1'b1, alu_op(), 1'b1, 1'b0);
      cyc(1'b1, alu_op(), 1'b1, 1'b1);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 40 && backend.size() != 0; i++)
         cyc(1'b0, 32'h0, 1'b1, 1'b0);

      // Asynchronous reset in SOLO with three entries queued.
      lat_sel = 20;
      cyc(1'b1, serial_op(), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++)
         cyc(1'b1, alu_op(), 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      do_reset();

      // Random traffic with alternating downstream pressure.
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         logic [31:0] ins;
         rdy_pct = ((i / 200) % 2 == 0) ? 85 : 30;
         lat_sel = $urandom_range(1, 3);
         ins     = ($urandom_range(0, 99) < 25) ? serial_op() : alu_op();
         cyc($urandom_range(0, 99) < 70, ins,
             $urandom_range(0, 99) < rdy_pct,
             $urandom_range(0, 99) < 3);
      end
      idle(DEPTH + 10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_queue_issue_ctrl.md
Name: inst_queue_issue_ctrl

Overview:
- Instruction queue and issue sequencer between fetch and the instruction decoder.
- Buffers fetched instruction/PC pairs and presents the head entry to the decoder through a valid/ready handshake.
- Serializes ops flagged by the decoder (CP0 moves, TLB ops, ERET, SYSCALL, BREAK). Such an op issues only into an empty backend, and nothing issues behind it until it has drained.

Parameters:
- DEPTH, 8, number of queue entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  redirect/exception; discards all queued and incoming instructions.
- fetch_valid  in  1  fetch offers an instruction.
- fetch_inst  in  32  instruction word.
- fetch_pc  in  32  instruction PC.
- fetch_ready  out  1  queue accepts this cycle.
- dec_valid  out  1  head entry is presented for issue.
- dec_inst  out  32  head instruction word.
- dec_pc  out  32  head PC.
- dec_serial  in  1  decoder flag (combinational from dec_inst): head op is serializing.
- dec_ready  in  1  downstream accepts the head this cycle.
- pipe_empty  in  1  no issued instruction is in flight past decode. Must be 0 from the cycle after any issue until that instruction retires.
- serial_stall  out  1  issue is blocked by serialization (state DRAIN or SOLO).
- count  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset values (async, rst=1):
  - Queue empty; rd/wr pointers 0; count=0; state=RUN.
  - fetch_ready=1; dec_valid=0; dec_inst=0; dec_pc=0; serial_stall=0.
- Push and pop:
  - fetch_ready = (count != DEPTH).
  - push = fetch_valid & fetch_ready & !flush.
  - pop = dec_valid & dec_ready & !flush.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH.
  - A full queue does not accept a push even when a pop occurs in the same cycle.
- Latency: an instruction pushed in cycle N is first visible on dec_valid/dec_inst/dec_pc in cycle N+1.
- Empty queue: dec_valid=0. dec_inst and dec_pc hold their last value, or 0 after reset.
- Issue state machine:
  - RUN:
    - dec_valid = !empty & (!dec_serial | pipe_empty).
    - pop with dec_serial=1 -> SOLO.
    - !empty & dec_serial & !pipe_empty -> DRAIN.
  - DRAIN:
    - dec_valid = !empty & pipe_empty.
    - pop -> SOLO.
  - SOLO:
    - dec_valid=0.
    - Leaves to RUN on the first cycle with pipe_empty=1, counted from the cycle after entry. The pipe_empty value in the entry cycle itself is ignored.
  - serial_stall = (state==DRAIN) | (state==SOLO).
- Non-serializing ops issue back-to-back with no bubbles, one per cycle.
- Flush (highest priority):
  - In the flush cycle: no push, no pop, dec_valid=0.
  - Next edge: queue empty, count=0, state=RUN.
  - A flush during DRAIN or SOLO abandons serialization.
- A flush asserted together with rst is superseded by reset.
- dec_valid must not depend on dec_ready. dec_ready may depend on dec_valid.
- Once dec_valid=1 with dec_ready=0, dec_inst/dec_pc stay stable until pop or flush.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When the queue is empty, state=RUN and flush=0, fetch_inst/fetch_pc drive dec_inst/dec_pc combinationally.
  - dec_valid = fetch_valid & (!dec_serial | pipe_empty).
  - If bypass and dec_ready both hold, the entry is consumed without being written; count stays 0 and latency is 0 cycles.
  - Otherwise the entry is pushed normally.
- Undefined: always 1-cycle latency through storage, as above.

Test Plan:
- Reset, then push 0x24020001/pc 0xBFC00000 in cycle 1 with dec_ready=1 -> dec_valid=1 in cycle 2, dec_inst=0x24020001, dec_pc=0xBFC00000, count 1->0.
- Fill with DEPTH=8 pushes while dec_ready=0 -> count=8, fetch_ready=0. A 9th fetch_valid is not accepted. One pop -> fetch_ready=1 next cycle. Pointers wrap correctly over 3 full fill/drain rounds.
- Head 0x40806000 (MTC0) with dec_serial=1 and pipe_empty=0 for 3 cycles -> dec_valid=0, serial_stall=1. pipe_empty=1 -> issue. Next instruction is held in SOLO until pipe_empty returns 1, then it issues.
- Four ALU ops queued, dec_ready=1, dec_serial=0 -> issue in 4 consecutive cycles.
- Flush with count=5 while in DRAIN, with fetch_valid=1 in the same cycle -> next cycle count=0, state=RUN, dec_valid=0, and the incoming instruction is dropped.
- Assert rst mid-SOLO with count=3 -> all outputs return to reset values immediately, without waiting for a clock edge.
